// File: rtl/wb_dual_master_arbiter_if.sv
// Classic single-beat Wishbone link between one master and one slave.
//   cyc, stb, we   : cycle, strobe, write enable       (master -> slave)
//   sel            : byte selects, DATA_WIDTH/8 bits    (master -> slave)
//   adr            : address, ADDR_WIDTH bits           (master -> slave)
//   dat_w          : write data, DATA_WIDTH bits        (master -> slave)
//   dat_r          : read data, DATA_WIDTH bits         (slave -> master)
//   ack, err       : transfer acknowledge / error       (slave -> master)
// The arbiter's master-facing ports (m0_*/m1_*) use the slave modport. Its
// memory-facing port (s_*) uses the master modport.
interface wb_dual_master_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    ack;
    logic                    err;

    modport master (output cyc, stb, we, sel, adr, dat_w, input  dat_r, ack, err);
    modport slave  (input  cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin arbiter that merges the instruction-side (m0) and data-side (m1)
// Wishbone masters onto one classic single-beat Wishbone slave. A per-grant
// timeout makes sure a dead slave cannot hang the core.
// Ports:
//   clk, rst_n   : core clock, asynchronous active-low reset
//   m0, m1       : master links (mN_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i in,
//                  mN_dat_o/ack_o/err_o out); ack/err reach the owner only
//   s            : slave link (s_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o out,
//                  s_dat_i/ack_i/err_i in)
//   grant_o      : one-hot owner {m1,m0}, 00 while idle
//   timeout_o    : one-cycle pulse when a grant times out
module wb_dual_master_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    wb_dual_master_arbiter_if.slave  m0,
    wb_dual_master_arbiter_if.slave  m1,
    wb_dual_master_arbiter_if.master s,
    output logic [1:0]               grant_o,
    output logic                     timeout_o
);
    localparam int unsigned      CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;  // 1 = m1 owned the bus last
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                    m0_req, m1_req;
    logic                    owner;
    logic                    own_cyc, own_stb, own_we;
    logic [DATA_WIDTH/8-1:0] own_sel;
    logic [ADDR_WIDTH-1:0]   own_adr;
    logic [DATA_WIDTH-1:0]   own_dat;

    logic                    s_cyc, s_stb, s_we;
    logic [DATA_WIDTH/8-1:0] s_sel;
    logic [ADDR_WIDTH-1:0]   s_adr;
    logic [DATA_WIDTH-1:0]   s_dat;
    logic                    rsp_ack, rsp_err, tmo;
    logic [1:0]              grant;

    assign m0_req = m0.cyc & m0.stb;
    assign m1_req = m1.cyc & m1.stb;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        s_cyc        = 1'b0;
        s_stb        = 1'b0;
        s_we         = 1'b0;
        s_sel        = '0;
        s_adr        = '0;
        s_dat        = '0;
        rsp_ack      = 1'b0;
        rsp_err      = 1'b0;
        tmo          = 1'b0;
        grant        = 2'b00;

        owner   = (state_q == OWN1);
        own_cyc = owner ? m1.cyc   : m0.cyc;
        own_stb = owner ? m1.stb   : m0.stb;
        own_we  = owner ? m1.we    : m0.we;
        own_sel = owner ? m1.sel   : m0.sel;
        own_adr = owner ? m1.adr   : m0.adr;
        own_dat = owner ? m1.dat_w : m0.dat_w;

        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = last_grant_q ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
                // The counter holds the number of the current OWN cycle, so entry
                // loads 1 and the timeout fires when it equals TIMEOUT_CYCLES.
                cnt_d = (state_d != IDLE) ? CNT_W'(1) : '0;
            end
            OWN0, OWN1: begin
                grant = owner ? 2'b10 : 2'b01;
                s_cyc = own_cyc;
                s_stb = own_stb;
                s_we  = own_we;
                s_sel = own_sel;
                s_adr = own_adr;
                s_dat = own_dat;
                if (!own_cyc) begin
                    // Abort: the master withdrew, so nothing is returned to it.
                    s_stb        = 1'b0;
                    state_d      = IDLE;
                    last_grant_d = owner;
                    cnt_d        = '0;
                end else if (own_stb && (s.ack || s.err)) begin
                    // Error takes priority over a simultaneous ack.
                    rsp_err      = s.err;
                    rsp_ack      = s.ack & ~s.err;
                    state_d      = IDLE;
                    last_grant_d = owner;
                    cnt_d        = '0;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_TMO)) begin
                    s_cyc        = 1'b0;
                    s_stb        = 1'b0;
                    rsp_err      = 1'b1;
                    tmo          = 1'b1;
                    state_d      = IDLE;
                    last_grant_d = owner;
                    cnt_d        = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign s.cyc   = s_cyc;
    assign s.stb   = s_stb;
    assign s.we    = s_we;
    assign s.sel   = s_sel;
    assign s.adr   = s_adr;
    assign s.dat_w = s_dat;

    // Read data is shared by both masters but held at zero while idle, so the
    // asynchronous reset clears every output.
    assign m0.dat_r = (state_q != IDLE) ? s.dat_r : '0;
    assign m1.dat_r = (state_q != IDLE) ? s.dat_r : '0;
    assign m0.ack   = rsp_ack & ~owner;
    assign m0.err   = rsp_err & ~owner;
    assign m1.ack   = rsp_ack &  owner;
    assign m1.err   = rsp_err &  owner;

    assign grant_o   = grant;
    assign timeout_o = tmo;
endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
module tb_wb_dual_master_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cycle  = 0;

    // Expected response record: {cycle, grant, ack0, err0, ack1, err1, timeout, s_cyc, m0_dat, m1_dat}
    logic [103:0] exp_q[$];
    logic [103:0] mon_act;
    logic [1:0]   g2 [0:6];

    wb_dual_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    wb_dual_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    wb_dual_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

    wb_dual_master_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .grant_o  (grant_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] all_outs();
        return 160'({grant_o, timeout_o, m0_if.ack, m0_if.err, m1_if.ack, m1_if.err,
                     s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.adr, s_if.dat_w,
                     m0_if.dat_r, m1_if.dat_r});
    endfunction

    task automatic expect_rsp(input int unsigned at, input logic [1:0] g,
                              input logic a0, input logic e0, input logic a1, input logic e1,
                              input logic t, input logic sc, input logic [31:0] d);
        exp_q.push_back({at, g, a0, e0, a1, e1, t, sc, d, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [3:0] sel,
                            input logic [31:0] adr, input logic [31:0] dat);
        m0_if.cyc = req; m0_if.stb = req; m0_if.we = we;
        m0_if.sel = sel; m0_if.adr = adr; m0_if.dat_w = dat;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [3:0] sel,
                            input logic [31:0] adr, input logic [31:0] dat);
        m1_if.cyc = req; m1_if.stb = req; m1_if.we = we;
        m1_if.sel = sel; m1_if.adr = adr; m1_if.dat_w = dat;
    endtask

    // Monitor: every presented response is matched against the next expected one.
    always @(negedge clk) begin
        if (rst_n && (m0_if.ack || m0_if.err || m1_if.ack || m1_if.err || timeout_o)) begin
            mon_act = {cycle, grant_o, m0_if.ack, m0_if.err, m1_if.ack, m1_if.err,
                       timeout_o, s_if.cyc, m0_if.dat_r, m1_if.dat_r};
            if (exp_q.size() == 0)
                check("unexpected_rsp", 160'(mon_act), 160'(0));
            else
                check("rsp", 160'(mon_act), 160'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        logic        exp_cyc;
        g2 = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        s_if.ack = 1'b1; s_if.err = 1'b0; s_if.dat_r = 32'h12345678;

        // Reset state, with slave ack ignored
        repeat (2) @(posedge clk);
        #3;
        check("reset_outputs", all_outs(), 160'(0));
        step();
        rst_n = 1'b1; s_if.ack = 1'b0; s_if.dat_r = 32'h0BADF00D;
        #2;
        check("idle_outputs", all_outs(), 160'(0));

        // Both masters request continuously, 0-wait slave
        step();
        c0 = cycle;
        drive_m0(1'b1, 1'b0, 4'h3, 32'h10, 32'h11111111);
        drive_m1(1'b1, 1'b1, 4'hF, 32'h20, 32'hA5A5A5A5);
        s_if.ack = 1'b1;
        expect_rsp(c0 + 1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
        expect_rsp(c0 + 3, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
        expect_rsp(c0 + 5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
        expect_rsp(c0 + 7, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
        for (int i = 0; i < 7; i++) begin
            step();
            #2;
            check("t2_grant", 160'(grant_o), 160'(g2[i]));
            if (g2[i] == 2'b10)
                check("t2_m1_on_s", 160'({s_if.cyc, s_if.we, s_if.sel, s_if.adr, s_if.dat_w}),
                      160'({1'b1, 1'b1, 4'hF, 32'h20, 32'hA5A5A5A5}));
            else if (g2[i] == 2'b01)
                check("t2_m0_on_s", 160'({s_if.cyc, s_if.we, s_if.sel, s_if.adr, s_if.dat_w}),
                      160'({1'b1, 1'b0, 4'h3, 32'h10, 32'h11111111}));
            else
                check("t2_idle_s", 160'({s_if.cyc, s_if.stb, s_if.dat_w}), 160'(0));
        end
        step();
        drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        s_if.ack = 1'b0;

        // m0 read alone, slave acks in the second owned cycle
        step();
        c0 = cycle;
        drive_m0(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        s_if.dat_r = 32'h0;
        step();
        #2;
        check("t1_cycle1", 160'({grant_o, s_if.cyc, s_if.stb, s_if.we, s_if.adr}),
              160'({2'b01, 1'b1, 1'b1, 1'b0, 32'h100}));
        step();
        expect_rsp(c0 + 2, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        s_if.ack = 1'b1; s_if.dat_r = 32'hDEADBEEF;
        step();
        drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        s_if.ack = 1'b0;
        #2;
        check("t1_grant_c3", 160'(grant_o), 160'(2'b00));

        // Simultaneous ack and err: err wins; m1 waits, then completes
        step();
        c0 = cycle;
        drive_m0(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        s_if.dat_r = 32'h44444444;
        step();
        drive_m1(1'b1, 1'b0, 4'hF, 32'h304, 32'h0);
        expect_rsp(c0 + 1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44444444);
        s_if.ack = 1'b1; s_if.err = 1'b1;
        step();
        drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        s_if.ack = 1'b0; s_if.err = 1'b0;
        #2;
        check("t4_idle_grant", 160'(grant_o), 160'(2'b00));
        step();
        expect_rsp(c0 + 3, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55555555);
        s_if.ack = 1'b1; s_if.dat_r = 32'h55555555;
        step();
        drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        s_if.ack = 1'b0;

        // m0 aborts in its second owned cycle while the slave acks
        step();
        drive_m0(1'b1, 1'b1, 4'hF, 32'h400, 32'h99);
        step();
        #2;
        check("t5_owned", 160'({grant_o, s_if.cyc}), 160'({2'b01, 1'b1}));
        step();
        drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        s_if.ack = 1'b1;
        #2;
        check("t5_abort", 160'({grant_o, s_if.cyc, s_if.stb}), 160'({2'b01, 1'b0, 1'b0}));
        step();
        s_if.ack = 1'b0;
        #2;
        check("t5_grant_next", 160'(grant_o), 160'(2'b00));

        // m1 write to a silent slave times out; pending m0 follows
        step();
        c0 = cycle;
        drive_m1(1'b1, 1'b1, 4'hF, 32'h2000, 32'hCAFE0001);
        s_if.dat_r = 32'h66666666;
        expect_rsp(c0 + 4, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h66666666);
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 1) drive_m0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
            #2;
            exp_cyc = (i < 4);
            check("t3_grant", 160'(grant_o), 160'(2'b10));
            check("t3_s_cyc", 160'(s_if.cyc), 160'(exp_cyc));
        end
        step();
        drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #2;
        check("t3_idle", 160'(grant_o), 160'(2'b00));
        step();
        expect_rsp(c0 + 6, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h66666666);
        s_if.ack = 1'b1;
        #2;
        check("t3_m0_granted", 160'(grant_o), 160'(2'b01));
        step();
        drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        s_if.ack = 1'b0;

        // Asynchronous reset while m1 owns the bus
        step();
        drive_m1(1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
        s_if.dat_r = 32'h77777777;
        step();
        #2;
        check("t6_owned", 160'(grant_o), 160'(2'b10));
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", all_outs(), 160'(0));
        step();
        step();
        rst_n = 1'b1;
        drive_m0(1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
        c0 = cycle;
        step();
        expect_rsp(c0 + 1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77777777);
        s_if.ack = 1'b1;
        #2;
        check("t6_tie_to_m0", 160'(grant_o), 160'(2'b01));
        step();
        drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        s_if.ack = 1'b0;
        step();
        step();
        check("pending_expected", 160'(exp_q.size()), 160'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
